// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-requester arbiter sharing one single-port memory (req0 = CPU, req1 = loader)
// Ports: clock, n_rst (sync, active-low); per requester reqN/weN/addrN/wdataN in, gntN/ackN pulses out;
// rdata (valid with ack), stall0 = req0 & ~ack0; mem_en/mem_we/mem_addr/mem_dout to the macro, mem_din back.
// Define MEM_BUS_ARB_RR_EN for round-robin on ties; otherwise req0 has fixed priority.
module mem_bus_arb #(
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              n_rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [DATA_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [DATA_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              stall0,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dout,
   input  logic [DATA_W-1:0] mem_din
);
   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
   state_t state, state_n;
   logic owner, owner_n, last_owner, last_owner_n, wr, wr_n, win;
   logic gnt0_n, gnt1_n, ack0_n, ack1_n, mem_en_n, mem_we_n;
   logic [3:0] cnt, cnt_n;
   logic [DATA_W-1:0] rdata_n, mem_addr_n, mem_dout_n;
   assign stall0 = req0 & ~ack0;
`ifdef MEM_BUS_ARB_RR_EN
   assign win = req1 & (~req0 | ~last_owner);
`else
   assign win = ~req0;
`endif
   // BUSY runs MEM_LAT+1 cycles: mem_en covers the MEM_LAT issue cycles, the final cycle captures mem_din.
   always_comb begin
      state_n      = state;
      owner_n      = owner;
      last_owner_n = last_owner;
      wr_n         = wr;
      cnt_n        = cnt;
      gnt0_n       = 1'b0;
      gnt1_n       = 1'b0;
      ack0_n       = 1'b0;
      ack1_n       = 1'b0;
      mem_en_n     = mem_en;
      mem_we_n     = 1'b0;
      mem_addr_n   = mem_addr;
      mem_dout_n   = mem_dout;
      rdata_n      = rdata;
      case (state)
         IDLE: if (req0 | req1) begin
            state_n    = BUSY;
            owner_n    = win;
            gnt0_n     = ~win;
            gnt1_n     = win;
            mem_en_n   = 1'b1;
            mem_we_n   = win ? we1 : we0;
            wr_n       = win ? we1 : we0;
            mem_addr_n = win ? addr1 : addr0;
            mem_dout_n = win ? wdata1 : wdata0;
            cnt_n      = 4'(MEM_LAT);
         end
         BUSY: if (cnt != 4'd0) begin
            cnt_n    = cnt - 4'd1;
            mem_en_n = cnt != 4'd1;
         end else begin
            rdata_n      = wr ? rdata : mem_din;
            ack0_n       = ~owner;
            ack1_n       = owner;
            mem_en_n     = 1'b0;
            last_owner_n = owner;
            state_n      = ACK;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!n_rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         wr         <= 1'b0;
         cnt        <= 4'd0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_dout   <= '0;
         rdata      <= '0;
      end else begin
         state      <= state_n;
         owner      <= owner_n;
         last_owner <= last_owner_n;
         wr         <= wr_n;
         cnt        <= cnt_n;
         gnt0       <= gnt0_n;
         gnt1       <= gnt1_n;
         ack0       <= ack0_n;
         ack1       <= ack1_n;
         mem_en     <= mem_en_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_dout   <= mem_dout_n;
         rdata      <= rdata_n;
      end
   end
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed bench for mem_bus_arb at MEM_LAT=1 (dut) and MEM_LAT=3 (s_dut)
module tb_mem_bus_arb;
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic n_rst, req0, we0, req1, we1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic gnt0, gnt1, ack0, ack1, stall0, mem_en, mem_we;
   logic [15:0] rdata, mem_addr, mem_dout, mem_din;
   logic s_gnt0, s_gnt1, s_ack0, s_ack1, s_stall0, s_mem_en, s_mem_we;
   logic [15:0] s_rdata, s_mem_addr, s_mem_dout, s_mem_din;
   logic [15:0] m1 [0:255];
   logic [15:0] m3 [0:255];
   logic [15:0] p0, p1;
   int n_chk = 0, n_fail = 0;
   int en_cnt, ack_at, gnt_at, k;
   int ord [4];
   int gc [4];
   mem_bus_arb #(.DATA_W(16), .MEM_LAT(1)) dut (
      .clock(clock), .n_rst(n_rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
      .rdata(rdata), .stall0(stall0), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din));
   mem_bus_arb #(.DATA_W(16), .MEM_LAT(3)) s_dut (
      .clock(clock), .n_rst(n_rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(s_gnt0), .ack0(s_ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(s_gnt1), .ack1(s_ack1),
      .rdata(s_rdata), .stall0(s_stall0), .mem_en(s_mem_en), .mem_we(s_mem_we),
      .mem_addr(s_mem_addr), .mem_dout(s_mem_dout), .mem_din(s_mem_din));
   always @(posedge clock) begin
      if (mem_en && mem_we) m1[mem_addr[7:0]] <= mem_dout;
      if (mem_en) mem_din <= m1[mem_addr[7:0]];
   end
   always @(posedge clock) begin
      if (s_mem_en && s_mem_we) m3[s_mem_addr[7:0]] <= s_mem_dout;
      if (s_mem_en) p0 <= m3[s_mem_addr[7:0]];
      p1 <= p0;
      s_mem_din <= p1;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset;
      n_rst = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      tick;
      tick;
      n_rst = 1'b1;
   endtask
   initial begin
      for (int i = 0; i < 256; i++) begin
         m1[i] = 16'h0;
         m3[i] = 16'h0;
      end
      m1[16] = 16'hBEEF;
      m3[16] = 16'hBEEF;
      mem_din = 16'h0;
      p0 = 16'h0;
      p1 = 16'h0;
      s_mem_din = 16'h0;
      we0 = 1'b0; we1 = 1'b0;
      addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
      do_reset;
      check("rst_gnt0", gnt0, 0);
      check("rst_ack0", ack0, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rdata", rdata, 0);
      check("rst_stall0", stall0, 0);
      // MEM_LAT=3 timing, observed on s_dut
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      tick;
      check("l3_gnt0", s_gnt0, 1);
      en_cnt = s_mem_en; ack_at = 0; gnt_at = 0;
      for (int i = 1; i <= 10; i++) begin
         tick;
         if (ack_at == 0) en_cnt += s_mem_en;
         if (s_ack0 && ack_at == 0) begin
            ack_at = i;
            check("l3_rdata", s_rdata, 16'hBEEF);
         end
         if (s_gnt0 && gnt_at == 0) gnt_at = i;
      end
      check("l3_en_cycles", en_cnt, 3);
      check("l3_ack_at", ack_at, 4);
      check("l3_next_gnt", gnt_at, 6);
      do_reset;
      // basic read with stall
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      #1;
      check("rd_stall_req", stall0, 1);
      tick;
      check("rd_gnt0", gnt0, 1);
      check("rd_mem_en", mem_en, 1);
      check("rd_mem_addr", mem_addr, 16'h0010);
      check("rd_stall_g", stall0, 1);
      tick;
      check("rd_gnt0_pulse", gnt0, 0);
      check("rd_ack_early", ack0, 0);
      check("rd_stall_g1", stall0, 1);
      tick;
      check("rd_ack0", ack0, 1);
      check("rd_rdata", rdata, 16'hBEEF);
      check("rd_stall_ack", stall0, 0);
      req0 = 1'b0;
      tick;
      check("rd_ack0_pulse", ack0, 0);
      // write from loader
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234;
      tick;
      check("wr_gnt1", gnt1, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, 16'h0020);
      check("wr_mem_dout", mem_dout, 16'h1234);
      req1 = 1'b0;
      tick;
      check("wr_mem_we_clr", mem_we, 0);
      tick;
      check("wr_ack1", ack1, 1);
      check("wr_ack0_quiet", ack0, 0);
      check("wr_mem_we_ack", mem_we, 0);
      check("wr_rdata_kept", rdata, 16'hBEEF);
      tick;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
      tick;
      check("rb_gnt0", gnt0, 1);
      tick;
      tick;
      check("rb_ack0", ack0, 1);
      check("rb_rdata", rdata, 16'h1234);
      do_reset;
      // both requesters held for four grants
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0010; addr1 = 16'h0020;
      k = 0;
      for (int j = 0; j < 4; j++) begin
         ord[j] = 9;
         gc[j] = 0;
      end
      for (int i = 0; i < 40 && k < 4; i++) begin
         tick;
         check("gnt_excl", gnt0 & gnt1, 0);
         check("ack_excl", ack0 & ack1, 0);
         if (gnt0 | gnt1) begin
            ord[k] = int'(gnt1);
            gc[k] = i;
            k++;
         end
      end
      check("n_grants", k, 4);
      for (int j = 0; j < 4; j++) begin
`ifdef MEM_BUS_ARB_RR_EN
         check("grant_order", ord[j], j % 2);
`else
         check("grant_order", ord[j], 0);
`endif
      end
      for (int j = 1; j < 4; j++) check("grant_spacing", gc[j] - gc[j-1], 4);
      do_reset;
      // reset in the second BUSY cycle of a read
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      tick;
      check("mr_gnt0", gnt0, 1);
      tick;
      n_rst = 1'b0; req0 = 1'b0;
      tick;
      check("mr_no_ack", ack0, 0);
      check("mr_mem_en", mem_en, 0);
      check("mr_rdata", rdata, 0);
      n_rst = 1'b1;
      tick;
      check("mr_idle_ack", ack0, 0);
      req0 = 1'b1;
      tick;
      check("mr_regnt", gnt0, 1);
      tick;
      tick;
      check("mr_reack", ack0, 1);
      check("mr_rerdata", rdata, 16'hBEEF);
      req0 = 1'b0;
      tick;
      // inputs changed during BUSY are ignored
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h5A5A;
      tick;
      check("hold_gnt0", gnt0, 1);
      req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0040; wdata0 = 16'hFFFF;
      tick;
      check("hold_addr", mem_addr, 16'h0030);
      check("hold_dout", mem_dout, 16'h5A5A);
      tick;
      check("hold_ack0", ack0, 1);
      check("hold_addr_ack", mem_addr, 16'h0030);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
